// File: rtl/sprite_renderer_if.sv
// Pixel stream, game-object state and colour output of the sprite renderer.
// The game logic (master) drives the i_* signals; the renderer (slave) drives the o_* signals.
interface sprite_renderer_if;
    logic              i_frame_start;
    logic              i_valid;
    logic [9:0]        i_px;
    logic [8:0]        i_py;
    logic [1:0]        i_state;
    logic              i_is_gaming;
    logic signed [10:0] i_player_x;
    logic signed [9:0]  i_player_y;
    logic [1:0]        i_player_hp;
    logic              i_player_shield;
    logic              i_player_squat;
    logic signed [10:0] i_enemy_x;
    logic signed [9:0]  i_enemy_y;
    logic [1:0]        i_enemy_hp;
    logic              i_enemy_shield;
    logic              i_enemy_squat;
    logic signed [10:0] i_goodbullet_x;
    logic signed [9:0]  i_goodbullet_y;
    logic              i_goodbullet_ise;
    logic signed [10:0] i_badbullet_x;
    logic signed [9:0]  i_badbullet_y;
    logic              i_badbullet_ise;
    logic [7:0]        o_r;
    logic [7:0]        o_g;
    logic [7:0]        o_b;
    logic              o_valid;

    modport master (
        output i_frame_start, i_valid, i_px, i_py, i_state, i_is_gaming,
               i_player_x, i_player_y, i_player_hp, i_player_shield, i_player_squat,
               i_enemy_x, i_enemy_y, i_enemy_hp, i_enemy_shield, i_enemy_squat,
               i_goodbullet_x, i_goodbullet_y, i_goodbullet_ise,
               i_badbullet_x, i_badbullet_y, i_badbullet_ise,
        input  o_r, o_g, o_b, o_valid
    );

    modport slave (
        input  i_frame_start, i_valid, i_px, i_py, i_state, i_is_gaming,
               i_player_x, i_player_y, i_player_hp, i_player_shield, i_player_squat,
               i_enemy_x, i_enemy_y, i_enemy_hp, i_enemy_shield, i_enemy_squat,
               i_goodbullet_x, i_goodbullet_y, i_goodbullet_ise,
               i_badbullet_x, i_badbullet_y, i_badbullet_ise,
        output o_r, o_g, o_b, o_valid
    );
endinterface

// File: rtl/sprite_renderer.sv
// Two-stage pixel colour pipeline for a two-character shooter. Object state is
// shadowed once per frame so a frame is always drawn from one consistent snapshot.
module sprite_renderer #(
    parameter int SPR_W        = 32,
    parameter int BUL_W        = 8,
    parameter int FLASH_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sprite_renderer_if.slave bus
);
    typedef enum logic [1:0] {ST_START = 2'b00, ST_PLAY = 2'b01, ST_WIN = 2'b10, ST_LOSE = 2'b11} game_state_e;

    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [FW-1:0]      FLASH_LOAD = FW'(FLASH_FRAMES);
    localparam logic signed [11:0] ZERO12     = 12'sd0;
    localparam logic signed [11:0] SPR_LAST   = 12'(SPR_W - 1);
    localparam logic signed [11:0] SQ_TOP     = 12'(SPR_W / 2);
    localparam logic signed [11:0] BUL_LAST   = 12'(BUL_W - 1);

    localparam logic [23:0] C_BAD   = 24'hFF4040;
    localparam logic [23:0] C_GOOD  = 24'h40FFFF;
    localparam logic [23:0] C_PL    = 24'h2080FF;
    localparam logic [23:0] C_EN    = 24'hFFA000;
    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_HUD_F = 24'hFF0080;
    localparam logic [23:0] C_HUD_E = 24'h404040;
    localparam logic [23:0] C_BG    = 24'h101010;
    localparam logic [23:0] C_START = 24'h000080;
    localparam logic [23:0] C_WIN   = 24'h00A000;
    localparam logic [23:0] C_LOSE  = 24'hA00000;

    // Returns {hit, outline}; a squatting character loses its upper half.
    function automatic logic [1:0] char_hit(input logic signed [11:0] cx, input logic signed [11:0] cy,
                                            input logic signed [10:0] x, input logic signed [9:0] y,
                                            input logic squat);
        logic signed [11:0] dx;
        logic signed [11:0] dy;
        logic signed [11:0] top;
        logic               hit;
        logic               ring;
        dx   = cx - $signed({x[10], x});
        dy   = cy - $signed({{2{y[9]}}, y});
        top  = squat ? SQ_TOP : ZERO12;
        hit  = (dx >= ZERO12) && (dx <= SPR_LAST) && (dy >= top) && (dy <= SPR_LAST);
        ring = (dx == ZERO12) || (dx == SPR_LAST) || (dy == top) || (dy == SPR_LAST);
        return {hit, hit & ring};
    endfunction

    function automatic logic bul_hit(input logic signed [11:0] cx, input logic signed [11:0] cy,
                                     input logic signed [10:0] x, input logic signed [9:0] y,
                                     input logic ise);
        logic signed [11:0] dx;
        logic signed [11:0] dy;
        dx = cx - $signed({x[10], x});
        dy = cy - $signed({{2{y[9]}}, y});
        return ise && (dx >= ZERO12) && (dx <= BUL_LAST) && (dy >= ZERO12) && (dy <= BUL_LAST);
    endfunction

    function automatic logic in_box(input logic [9:0] px, input logic [9:0] lo);
        return (px >= lo) && (px <= lo + 10'd15);
    endfunction

    function automatic logic [FW-1:0] flash_next(input logic [FW-1:0] cnt, input logic [1:0] new_hp,
                                                 input logic [1:0] old_hp);
        logic [FW-1:0] nxt;
        if (new_hp < old_hp) begin
            nxt = FLASH_LOAD;
        end else if (cnt != '0) begin
            nxt = cnt - FW'(1);
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    game_state_e        state_r;
    logic signed [10:0] pl_x_r, en_x_r, gb_x_r, bb_x_r;
    logic signed [9:0]  pl_y_r, en_y_r, gb_y_r, bb_y_r;
    logic [1:0]         pl_hp_r, en_hp_r;
    logic               pl_shield_r, pl_squat_r, en_shield_r, en_squat_r, gb_ise_r, bb_ise_r;
    logic [FW-1:0]      pl_flash_r, en_flash_r;

    logic signed [11:0] px12_s, py12_s;
    logic [1:0]         pl_t_s, en_t_s;
    logic               pl_white_s, en_white_s, hud_hit_s, hud_fill_s;

    logic               v1_r, bb_hit_r, gb_hit_r, pl_hit_r, pl_white_r, en_hit_r, en_white_r;
    logic               hud_hit_r, hud_fill_r;
    game_state_e        st1_state_r;
    logic [23:0]        colour_s;
    logic [23:0]        rgb_r;
    logic               o_valid_r;

    // Frame-start shadow of every game-object input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_START;
            pl_x_r      <= 11'sd0;  pl_y_r <= 10'sd0;  pl_hp_r <= 2'd3;
            pl_shield_r <= 1'b0;    pl_squat_r <= 1'b0;
            en_x_r      <= 11'sd0;  en_y_r <= 10'sd0;  en_hp_r <= 2'd3;
            en_shield_r <= 1'b0;    en_squat_r <= 1'b0;
            gb_x_r      <= 11'sd0;  gb_y_r <= 10'sd0;  gb_ise_r <= 1'b0;
            bb_x_r      <= 11'sd0;  bb_y_r <= 10'sd0;  bb_ise_r <= 1'b0;
        end else if (bus.i_frame_start) begin
            state_r     <= game_state_e'(bus.i_state);
            pl_x_r      <= bus.i_player_x;  pl_y_r <= bus.i_player_y;  pl_hp_r <= bus.i_player_hp;
            pl_shield_r <= bus.i_player_shield;  pl_squat_r <= bus.i_player_squat;
            en_x_r      <= bus.i_enemy_x;   en_y_r <= bus.i_enemy_y;   en_hp_r <= bus.i_enemy_hp;
            en_shield_r <= bus.i_enemy_shield;   en_squat_r <= bus.i_enemy_squat;
            gb_x_r      <= bus.i_goodbullet_x;  gb_y_r <= bus.i_goodbullet_y;  gb_ise_r <= bus.i_goodbullet_ise;
            bb_x_r      <= bus.i_badbullet_x;   bb_y_r <= bus.i_badbullet_y;   bb_ise_r <= bus.i_badbullet_ise;
        end else begin
            state_r <= state_r;
        end
    end

    // Hit-flash counters compare the incoming hp with the previously latched hp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_flash_r <= '0;
            en_flash_r <= '0;
        end else if (!bus.i_is_gaming) begin
            pl_flash_r <= '0;
            en_flash_r <= '0;
        end else if (bus.i_frame_start) begin
            pl_flash_r <= flash_next(pl_flash_r, bus.i_player_hp, pl_hp_r);
            en_flash_r <= flash_next(en_flash_r, bus.i_enemy_hp, en_hp_r);
        end else begin
            pl_flash_r <= pl_flash_r;
            en_flash_r <= en_flash_r;
        end
    end

    // Stage-1 hit tests against the shadowed objects.
    always_comb begin
        px12_s     = $signed({2'b00, bus.i_px});
        py12_s     = $signed({3'b000, bus.i_py});
        pl_t_s     = char_hit(px12_s, py12_s, pl_x_r, pl_y_r, pl_squat_r);
        en_t_s     = char_hit(px12_s, py12_s, en_x_r, en_y_r, en_squat_r);
        pl_white_s = (pl_t_s[0] & pl_shield_r) | (pl_t_s[1] & (pl_flash_r != '0) & pl_flash_r[1]);
        en_white_s = (en_t_s[0] & en_shield_r) | (en_t_s[1] & (en_flash_r != '0) & en_flash_r[1]);
        hud_hit_s  = 1'b0;
        hud_fill_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hud_hit_s  = hud_hit_s | in_box(bus.i_px, 10'(8 + 24 * k)) | in_box(bus.i_px, 10'(616 - 24 * k));
            hud_fill_s = hud_fill_s
                       | (in_box(bus.i_px, 10'(8 + 24 * k))   & (2'(k) < pl_hp_r))
                       | (in_box(bus.i_px, 10'(616 - 24 * k)) & (2'(k) < en_hp_r));
        end
        hud_hit_s  = hud_hit_s  & (bus.i_py >= 9'd8) & (bus.i_py <= 9'd23);
        hud_fill_s = hud_fill_s & hud_hit_s;
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;  st1_state_r <= ST_START;
            bb_hit_r <= 1'b0;  gb_hit_r <= 1'b0;
            pl_hit_r <= 1'b0;  pl_white_r <= 1'b0;  en_hit_r <= 1'b0;  en_white_r <= 1'b0;
            hud_hit_r <= 1'b0;  hud_fill_r <= 1'b0;
        end else begin
            v1_r <= bus.i_valid;  st1_state_r <= state_r;
            bb_hit_r <= bul_hit(px12_s, py12_s, bb_x_r, bb_y_r, bb_ise_r);
            gb_hit_r <= bul_hit(px12_s, py12_s, gb_x_r, gb_y_r, gb_ise_r);
            pl_hit_r <= pl_t_s[1];  pl_white_r <= pl_white_s;
            en_hit_r <= en_t_s[1];  en_white_r <= en_white_s;
            hud_hit_r <= hud_hit_s;  hud_fill_r <= hud_fill_s;
        end
    end

    // Stage-2 colour resolution.
    always_comb begin
        colour_s = 24'h000000;
        case (st1_state_r)
            ST_START: colour_s = C_START;
            ST_WIN:   colour_s = C_WIN;
            ST_LOSE:  colour_s = C_LOSE;
            ST_PLAY: begin
                if (bb_hit_r) begin
                    colour_s = C_BAD;
                end else if (gb_hit_r) begin
                    colour_s = C_GOOD;
                end else if (pl_hit_r) begin
                    colour_s = pl_white_r ? C_WHITE : C_PL;
                end else if (en_hit_r) begin
                    colour_s = en_white_r ? C_WHITE : C_EN;
                end else if (hud_hit_r) begin
                    colour_s = hud_fill_r ? C_HUD_F : C_HUD_E;
                end else begin
                    colour_s = C_BG;
                end
            end
            default: colour_s = 24'h000000;
        endcase
        if (!v1_r) begin
            colour_s = 24'h000000;
        end else begin
            colour_s = colour_s;
        end
    end

    // Stage-2 output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r     <= 24'h000000;
            o_valid_r <= 1'b0;
        end else begin
            rgb_r     <= colour_s;
            o_valid_r <= v1_r;
        end
    end

    assign bus.o_r     = rgb_r[23:16];
    assign bus.o_g     = rgb_r[15:8];
    assign bus.o_b     = rgb_r[7:0];
    assign bus.o_valid = o_valid_r;
endmodule

// File: tb/tb_sprite_renderer.sv
// Directed, table-driven bench for sprite_renderer with hand-computed colours.
module tb_sprite_renderer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sprite_renderer_if bus();

    sprite_renderer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          scene;
        int          px;
        int          py;
        logic [23:0] rgb;
    } vec_t;

    localparam logic [23:0] BG = 24'h101010;
    localparam logic [23:0] PL = 24'h2080FF;
    localparam logic [23:0] EN = 24'hFFA000;
    localparam logic [23:0] WH = 24'hFFFFFF;

    task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got valid/rgb=%h expected %h", name, act, exp);
        end
    endtask

    task automatic probe(input int x, input int y, output logic [24:0] res);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_px    = 10'(x);
        bus.i_py    = 9'(y);
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        res = {bus.o_valid, bus.o_r, bus.o_g, bus.o_b};
    endtask

    task automatic new_frame();
        @(negedge clk);
        bus.i_frame_start = 1'b1;
        @(negedge clk);
        bus.i_frame_start = 1'b0;
    endtask

    task automatic set_scene(input int s);
        bus.i_state = 2'b01;  bus.i_is_gaming = 1'b1;
        bus.i_player_x = 11'sd100;  bus.i_player_y = 10'sd200;  bus.i_player_hp = 2'd3;
        bus.i_player_shield = 1'b0;  bus.i_player_squat = 1'b0;
        bus.i_enemy_x = 11'sd400;  bus.i_enemy_y = 10'sd300;  bus.i_enemy_hp = 2'd3;
        bus.i_enemy_shield = 1'b0;  bus.i_enemy_squat = 1'b0;
        bus.i_goodbullet_x = 11'sd300;  bus.i_goodbullet_y = 10'sd100;  bus.i_goodbullet_ise = 1'b0;
        bus.i_badbullet_x = 11'sd100;  bus.i_badbullet_y = 10'sd200;  bus.i_badbullet_ise = 1'b0;
        case (s)
            1: bus.i_player_squat = 1'b1;
            2: begin
                bus.i_badbullet_ise = 1'b1;  bus.i_goodbullet_ise = 1'b1;
                bus.i_enemy_x = 11'sd110;  bus.i_enemy_y = 10'sd210;
            end
            3: begin
                bus.i_goodbullet_ise = 1'b1;
                bus.i_enemy_x = 11'sd110;  bus.i_enemy_y = 10'sd210;
            end
            4: begin
                bus.i_enemy_x = -11'sd10;  bus.i_enemy_y = 10'sd50;
                bus.i_player_x = 11'sd620;  bus.i_player_y = 10'sd470;
            end
            5: bus.i_player_shield = 1'b1;
            6: begin bus.i_state = 2'b00; bus.i_is_gaming = 1'b0; end
            7: begin bus.i_state = 2'b10; bus.i_is_gaming = 1'b0; end
            8: begin bus.i_state = 2'b11; bus.i_is_gaming = 1'b0; end
            default: bus.i_state = 2'b01;
        endcase
    endtask

    initial begin
        vec_t        vecs[$];
        logic [24:0] res;
        logic [9:0]  white_pat;
        int          cur;

        checks = 0;  failures = 0;
        rst_n = 1'b0;
        bus.i_frame_start = 1'b0;  bus.i_valid = 1'b0;  bus.i_px = 10'd0;  bus.i_py = 9'd0;
        set_scene(0);

        vecs.push_back('{0, 100, 200, PL});  vecs.push_back('{0, 99, 200, BG});
        vecs.push_back('{0, 132, 200, BG});  vecs.push_back('{0, 131, 231, PL});
        vecs.push_back('{0, 100, 232, BG});  vecs.push_back('{0, 431, 331, EN});
        vecs.push_back('{0, 8, 8, 24'hFF0080});   vecs.push_back('{0, 23, 23, 24'hFF0080});
        vecs.push_back('{0, 24, 8, BG});          vecs.push_back('{0, 56, 15, 24'hFF0080});
        vecs.push_back('{0, 71, 24, BG});         vecs.push_back('{0, 631, 8, 24'hFF0080});
        vecs.push_back('{0, 568, 20, 24'hFF0080}); vecs.push_back('{0, 584, 20, BG});
        vecs.push_back('{0, 7, 8, BG});
        vecs.push_back('{1, 110, 210, BG});  vecs.push_back('{1, 110, 215, BG});
        vecs.push_back('{1, 110, 216, PL});  vecs.push_back('{1, 110, 220, PL});
        vecs.push_back('{2, 100, 200, 24'hFF4040});  vecs.push_back('{2, 107, 207, 24'hFF4040});
        vecs.push_back('{2, 108, 200, PL});          vecs.push_back('{2, 300, 100, 24'h40FFFF});
        vecs.push_back('{2, 307, 107, 24'h40FFFF});  vecs.push_back('{2, 308, 100, BG});
        vecs.push_back('{3, 100, 200, PL});  vecs.push_back('{3, 120, 220, PL});
        vecs.push_back('{3, 141, 241, EN});  vecs.push_back('{3, 300, 100, 24'h40FFFF});
        vecs.push_back('{4, 0, 50, EN});     vecs.push_back('{4, 21, 81, EN});
        vecs.push_back('{4, 22, 50, BG});    vecs.push_back('{4, 630, 50, BG});
        vecs.push_back('{4, 639, 81, BG});   vecs.push_back('{4, 639, 479, PL});
        vecs.push_back('{4, 619, 470, BG});  vecs.push_back('{4, 620, 469, BG});
        vecs.push_back('{5, 100, 200, WH});  vecs.push_back('{5, 101, 201, PL});
        vecs.push_back('{5, 131, 215, WH});  vecs.push_back('{5, 115, 231, WH});
        vecs.push_back('{5, 132, 215, BG});
        vecs.push_back('{6, 100, 200, 24'h000080});  vecs.push_back('{6, 8, 8, 24'h000080});
        vecs.push_back('{7, 100, 200, 24'h00A000});  vecs.push_back('{8, 0, 0, 24'hA00000});

        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.o_valid, bus.o_r, bus.o_g, bus.o_b}, 25'h0);
        rst_n = 1'b1;

        // Inputs say PLAY but no frame start yet: shadow is still START.
        probe(100, 200, res);
        chk("start_before_frame", res, {1'b1, 24'h000080});

        cur = -1;
        foreach (vecs[i]) begin
            if (vecs[i].scene != cur) begin
                cur = vecs[i].scene;
                set_scene(cur);
                new_frame();
            end
            probe(vecs[i].px, vecs[i].py, res);
            chk($sformatf("vec%0d_s%0d_%0d_%0d", i, vecs[i].scene, vecs[i].px, vecs[i].py),
                res, {1'b1, vecs[i].rgb});
        end

        repeat (3) @(negedge clk);
        chk("invalid_black", {bus.o_valid, bus.o_r, bus.o_g, bus.o_b}, 25'h0);

        set_scene(0);
        new_frame();
        bus.i_state = 2'b10;
        probe(100, 200, res);
        chk("win_mid_frame", res, {1'b1, PL});
        new_frame();
        probe(100, 200, res);
        chk("win_next_frame", res, {1'b1, 24'h00A000});

        // Flash counter 8,7,...,1,0,0 across frames: white while bit 1 set.
        set_scene(0);
        new_frame();
        bus.i_player_hp = 2'd2;
        white_pat = 10'b0001100110;
        for (int f = 0; f < 10; f++) begin
            new_frame();
            probe(110, 210, res);
            chk($sformatf("flash_f%0d", f), res, {1'b1, white_pat[f] ? WH : PL});
        end
        probe(56, 15, res);
        chk("hud_k2_empty", res, {1'b1, 24'h404040});
        probe(32, 15, res);
        chk("hud_k1_full", res, {1'b1, 24'hFF0080});

        bus.i_player_hp = 2'd1;
        new_frame();
        probe(110, 210, res);
        chk("reload_a_8", res, {1'b1, PL});
        new_frame();
        probe(110, 210, res);
        chk("reload_a_7", res, {1'b1, WH});
        bus.i_player_hp = 2'd0;
        new_frame();
        probe(110, 210, res);
        chk("reload_b_8", res, {1'b1, PL});
        new_frame();
        probe(110, 210, res);
        chk("reload_b_7", res, {1'b1, WH});
        probe(8, 8, res);
        chk("hud_hp0", res, {1'b1, 24'h404040});
        @(negedge clk);
        bus.i_is_gaming = 1'b0;
        @(negedge clk);
        bus.i_is_gaming = 1'b1;
        new_frame();
        probe(110, 210, res);
        chk("flash_cleared", res, {1'b1, PL});

        set_scene(0);
        new_frame();
        @(negedge clk);
        bus.i_valid = 1'b1;  bus.i_px = 10'd100;  bus.i_py = 9'd200;
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        chk("rst_async", {bus.o_valid, bus.o_r, bus.o_g, bus.o_b}, 25'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pipe_clear", {bus.o_valid, bus.o_r, bus.o_g, bus.o_b}, 25'h0);
        probe(100, 200, res);
        chk("rst_start", res, {1'b1, 24'h000080});
        new_frame();
        probe(100, 200, res);
        chk("rst_frame_play", res, {1'b1, PL});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
